maxpool_ctrl: RTL
=================

Name: maxpool_ctrl

Overview:
Sequencing controller for one 2x2 / stride-2 signed max-pooling stage on a raster pixel stream. It instantiates maxpool_buffer (LENGTH = WIDTH), tracks row/column position, and fires a max-reduction only when a complete, stride-aligned 2x2 window is present. It presents pooled results on a valid/ready output with backpressure to the upstream conv/activation stage.

Parameters:
WIDTH, 28, input frame width in pixels (>= 2); also the line-buffer LENGTH.
HEIGHT, 28, input frame height in rows (>= 2).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream pixel valid
in_ready  out  1  controller can accept a pixel this cycle
in_data  in  8  signed pixel, raster order
in_sof  in  1  start-of-frame marker, qualified by in_valid
out_valid  out  1  pooled result valid
out_ready  in  1  downstream accepts result
out_data  out  8  signed max of the 2x2 window
out_last  out  1  marks the final pooled result of a frame
err_sync  out  1  one-cycle pulse on frame resynchronisation

Behaviour:
- Accept = in_valid && in_ready. Only an accept advances counters and drives the buffer's data_valid_in (pixel_in = in_data).
- in_ready = !(out_valid && !out_ready). Combinational; no other stall source.
- Counters: col 0..WIDTH-1, row 0..HEIGHT-1, advance per accept. col wraps to 0 and increments row; at (HEIGHT-1, WIDTH-1) both wrap to 0.
- Fire condition on accept: row[0]==1 && col[0]==1 && row < 2*(HEIGHT/2) && col < 2*(WIDTH/2). An odd trailing row or column is consumed but never pooled (floor semantics).
- Pipeline:
  - Cycle t: a firing pixel is accepted. The buffer window updates at the end of t, and the pend flag sets at the same edge.
  - Cycle t+1: pend=1. out_data_next = signed max of the four window entries.
  - End of t+1: output register loads and pend clears.
  - Cycle t+2: out_valid=1.
  - Latency is 2 cycles from firing accept to out_valid.
- The in_ready rule guarantees the output register is free whenever pend=1. No pending result is ever dropped or overwritten. A new accept during the pend cycle is legal because the max is taken from the pre-edge window.
- out_valid holds with stable out_data/out_last until out_ready. It clears on handshake unless a new result loads at the same edge.
- out_last = 1 for the result fired at row 2*(HEIGHT/2)-1, col 2*(WIDTH/2)-1.
- Comparison is signed 8-bit (-128 < 127). No widening is needed.
- in_sof:
  - on an accept at (0,0): no effect.
  - on an accept at any other position: counters treat the pixel as (0,0), so after the accept col=1, row=0. err_sync pulses the next cycle, and any in-flight pend still completes.
  - Line-buffer contents are not flushed. Pooled rows only read the row above within the new frame.
- Reset (also applied to the buffer): col=row=0, pend=0, out_valid=0, out_data=0, out_last=0, err_sync=0. in_ready=1 during and after reset.
- Reset mid-frame discards pending and held results. The next pixel is treated as (0,0).

Test Plan:
- WIDTH=4, HEIGHT=4, pixels 0..15, in_valid=1 continuously, out_ready=1 -> outputs 5, 7, 13, 15. Each appears 2 cycles after accepting pixels 5, 7, 13, 15. out_last only on 15.
- Signed: 2x2 block {-5, -3, -100, -1} in a 2x2 frame -> out_data=-1 (0xFF). Block {-128, -128, -128, -128} -> -128.
- Backpressure: hold out_ready=0 after the first result -> out_valid=1 with out_data=5 held, in_ready=0, counters frozen. Release -> remaining 7, 13, 15 arrive in order with none lost.
- Odd dims WIDTH=5, HEIGHT=3, ramp 0..14 -> exactly two outputs: 6 and 8, with out_last on 8. Column 4 and row 2 are never pooled.
- in_sof asserted on pixel index 6 of a 4x4 frame -> err_sync pulses once. That pixel becomes (0,0), and the following 15 pixels pool as a fresh frame.
- rst asserted while out_valid=1 and pend=1 -> next cycle out_valid=0, in_ready=1. A fresh 4x4 ramp then reproduces 5, 7, 13, 15.

Source files
------------

// File: rtl/maxpool_ctrl.sv
// 2x2 / stride-2 signed max-pool sequencer over a raster pixel stream.
// maxpool_buffer keeps the last row plus two pixels; maxpool_ctrl tracks position and issues results.

module maxpool_buffer #(
  parameter int LENGTH = 28,
  parameter int DW     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_valid_in,
  input  logic [DW-1:0]       pixel_in,
  output logic [3:0][DW-1:0]  window
);
  localparam int DEPTH = LENGTH + 2;

  // taps[0] is the newest pixel; taps[LENGTH] sits directly above it one row back.
  logic [DEPTH-1:0][DW-1:0] taps;

  always_ff @(posedge clk) begin
    if (rst)
      taps <= '0;
    else if (data_valid_in)
      taps <= {taps[DEPTH-2:0], pixel_in};
  end

  // {up-left, up, left, current}
  assign window = {taps[LENGTH+1], taps[LENGTH], taps[1], taps[0]};
endmodule

module maxpool_ctrl #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err_sync
);
  localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int POOL_W = 2 * (WIDTH / 2);
  localparam int POOL_H = 2 * (HEIGHT / 2);

  localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(POOL_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(POOL_H - 1);

  logic [CW-1:0]     col, cur_col, nxt_col;
  logic [RW-1:0]     row, cur_row, nxt_row;
  logic              accept, fire, fire_last;
  logic              pend, pend_last;
  logic [3:0][7:0]   window;
  logic [7:0]        max_val;

  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Reset forces ready so nothing upstream sees a stall during reset.
  assign in_ready = rst || !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready && !rst;

  maxpool_buffer #(.LENGTH(WIDTH), .DW(8)) u_buf (
    .clk           (clk),
    .rst           (rst),
    .data_valid_in (accept),
    .pixel_in      (in_data),
    .window        (window)
  );

  // A start-of-frame pixel is re-addressed to (0,0) wherever the counters were.
  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
    nxt_col = cur_col + CW'(1);
    nxt_row = cur_row;
    if (cur_col == COL_MAX) begin
      nxt_col = '0;
      nxt_row = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
    end
  end

  assign fire = accept && cur_row[0] && cur_col[0]
             && (32'(cur_row) < POOL_H) && (32'(cur_col) < POOL_W);
  assign fire_last = (cur_row == LAST_ROW) && (cur_col == LAST_COL);

  // Max is taken from the window as it stands during the pend cycle.
  assign max_val = smax(smax(window[0], window[1]), smax(window[2], window[3]));

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      err_sync  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      err_sync  <= accept && in_sof && ((col != '0) || (row != '0));
      pend      <= fire;
      pend_last <= fire && fire_last;
      if (accept) begin
        col <= nxt_col;
        row <= nxt_row;
      end
      // in_ready gating guarantees the output slot is free whenever pend is set.
      if (pend) begin
        out_valid <= 1'b1;
        out_data  <= max_val;
        out_last  <= pend_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
